pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the 5-stage pipeline, replacing the fixed-width PC logic in the processor top. It evaluates the branch condition from EX stage, redirects or stalls the PC, and drives the IF/ID and ID/EX flush. It detects end-of-program with a pipeline-drain window and keeps saturating performance counters. It sits between the EX-stage pipeline outputs, the hazard controller and the instruction memory address input.

## Interface

Parameters:
- ADDR_SIZE, 5: instruction address width; `pc` is ADDR_SIZE+1 bits so overrun is detectable.
- MEM_LEN, 32: instruction memory length in words, ≤ 2^ADDR_SIZE.
- DATA_SIZE, 32: ALU result width.
- DRAIN_CYCLES, 3: cycles `pc` must stay at MEM_LEN before `done` asserts, ≥ 1.
- CNT_WIDTH, 16: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_flag  in  1  load-use stall from hazard control.
- ex_branch  in  3  EX branch mode: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE; 5–7 treated as none.
- ex_zero  in  1  ALU zero flag registered in EX/MEM.
- ex_alu_out  in  DATA_SIZE  ALU result registered in EX/MEM.
- ex_pc  in  ADDR_SIZE  PC of the branch instruction.
- ex_branch_offset  in  ADDR_SIZE  unsigned branch distance in words.
- ex_branch_direction  in  1  1 = backward (subtract), 0 = forward (add).
- pc  out  ADDR_SIZE+1  current fetch PC.
- inst_addr  out  ADDR_SIZE  pc[ADDR_SIZE-1:0], drives the instruction memory.
- branch_flag  out  1  branch taken this cycle (combinational).
- flush  out  1  squash IF/ID and ID/EX; equals branch_flag.
- done  out  1  program finished; sticky until reset.
- cycle_count, stall_count, branch_count  out  CNT_WIDTH each  saturating counters.

## Operation

- Branch condition, combinational:
  - BEQ: ex_zero.
  - BNE: !ex_zero.
  - BLT: ex_alu_out[DATA_SIZE-1].
  - BGE: !ex_alu_out[DATA_SIZE-1].
  - branch_flag = condition && !done.
- Target is computed in ADDR_SIZE+2-bit signed arithmetic as ex_pc ± ex_branch_offset.
  - Negative result or result ≥ MEM_LEN: target = MEM_LEN.
  - Otherwise: target is the computed value.
- PC update priority per cycle, highest first:
  - rst: pc = 0.
  - done: pc holds.
  - branch_flag: pc ← target. A branch overrides a simultaneous stall.
  - stall_flag: pc holds.
  - pc < MEM_LEN: pc ← pc+1.
  - Otherwise: pc holds at MEM_LEN and never wraps.
- Drain FSM:
  - RUN → DRAIN when the next pc equals MEM_LEN.
  - In DRAIN, a down-counter loads DRAIN_CYCLES and decrements each cycle.
  - Any branch_flag during DRAIN returns to RUN; the in-flight branch is honoured.
  - Counter reaching 0 → DONE. `done` = 1 in DONE.
  - DONE exits only on rst.
- Counters, all halted in DONE and saturating at 2^CNT_WIDTH−1:
  - cycle_count: +1 every cycle.
  - stall_count: +1 when stall_flag && !branch_flag.
  - branch_count: +1 when branch_flag.

## Timing

- Reset (async assert, sync release): pc = 0, done = 0, FSM = RUN, all counters = 0. branch_flag and flush follow their inputs and are 0 when ex_branch = 0.
- branch_flag and flush: zero latency from EX inputs. The redirected pc is visible one cycle after the edge.
- Stall: pc is unchanged on every edge where stall_flag = 1 and there is no branch.
- done rises DRAIN_CYCLES+1 edges after the edge on which pc became MEM_LEN, provided no branch intervenes.
- rst asserted mid-run clears all state immediately, regardless of the clock.

## Test plan

- Straight line, MEM_LEN=32, DRAIN_CYCLES=3, no branches or stalls:
  - Required: pc counts 0..32.
  - Required: done rises 4 edges after pc=32; cycle_count freezes at 36.
- BEQ backward: ex_pc=10, offset=4, direction=1, ex_zero=1.
  - Required: branch_flag=flush=1 in that cycle.
  - Required: pc=6 next cycle; branch_count=1.
- BLT and BGE with ex_alu_out=0x8000_0000:
  - Required: BLT is taken; BGE is not taken and pc increments.
  - With ex_alu_out=0, the results are reversed.
- Branch and stall in the same cycle:
  - Required: pc ← target.
  - Required: stall_count unchanged; branch_count +1.
- Branch target out of range:
  - Backward ex_pc=2, offset=5: required pc=32, then done after the drain window.
  - Branch arriving during DRAIN with target 8: required FSM back to RUN, pc=8, done stays 0.
- Reset and saturation, CNT_WIDTH=4:
  - rst asserted mid-run at pc=17: required pc=0, counters 0 asynchronously.
  - 20 stall cycles: required stall_count saturates at 15.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch resolve/redirect, stall hold, end-of-program drain, perf counters.
// branch_flag/flush are combinational from EX inputs; pc redirect lands one edge later; stall holds pc.
module pc_sequencer #(
  parameter int ADDR_SIZE    = 5,
  parameter int MEM_LEN      = 32,
  parameter int DATA_SIZE    = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_flag,
  input  logic [2:0]           ex_branch,
  input  logic                 ex_zero,
  input  logic [DATA_SIZE-1:0] ex_alu_out,
  input  logic [ADDR_SIZE-1:0] ex_pc,
  input  logic [ADDR_SIZE-1:0] ex_branch_offset,
  input  logic                 ex_branch_direction,
  output logic [ADDR_SIZE:0]   pc,
  output logic [ADDR_SIZE-1:0] inst_addr,
  output logic                 branch_flag,
  output logic                 flush,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] branch_count
);

  localparam int TW = ADDR_SIZE + 2;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDR_SIZE:0] PC_END     = (ADDR_SIZE + 1)'(MEM_LEN);
  localparam logic [DW-1:0]      DRAIN_LOAD = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [ADDR_SIZE:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, stl_q, stl_d, brc_q, brc_d;
  logic                 cond, done_w;
  logic [TW-1:0]        tgt_sum;
  logic [ADDR_SIZE:0]   target;

  // Only the sign bit of the ALU result matters for BLT/BGE.
  logic unused_alu_bits;
  assign unused_alu_bits = ^ex_alu_out[DATA_SIZE-2:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cond = 1'b0;
    case (ex_branch)
      3'd1:    cond = ex_zero;
      3'd2:    cond = ~ex_zero;
      3'd3:    cond = ex_alu_out[DATA_SIZE-1];
      3'd4:    cond = ~ex_alu_out[DATA_SIZE-1];
      default: cond = 1'b0;
    endcase
  end

  assign branch_flag = cond & ~done_w;
  assign flush       = branch_flag;

  // Two guard bits: the MSB flags a negative result, the next one catches overflow past 2^ADDR_SIZE.
  always_comb begin
    if (ex_branch_direction)
      tgt_sum = {2'b00, ex_pc} - {2'b00, ex_branch_offset};
    else
      tgt_sum = {2'b00, ex_pc} + {2'b00, ex_branch_offset};
    if (tgt_sum[TW-1] || (tgt_sum[TW-2:0] >= PC_END))
      target = PC_END;
    else
      target = tgt_sum[TW-2:0];
  end

  always_comb begin
    pc_d = pc_q;
    if (done_w)
      pc_d = pc_q;
    else if (branch_flag)
      pc_d = target;
    else if (stall_flag)
      pc_d = pc_q;
    else if (pc_q < PC_END)
      pc_d = pc_q + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_RUN: begin
        if (pc_d == PC_END) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        if (branch_flag)
          state_d = S_RUN;
        else if (drain_q == '0)
          state_d = S_DONE;
        else
          drain_d = drain_q - 1'b1;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    done_w = (state_q == S_DONE);
  end

  always_comb begin
    cyc_d = cyc_q;
    stl_d = stl_q;
    brc_d = brc_q;
    if (!done_w) begin
      cyc_d = sat_inc(cyc_q);
      if (stall_flag && !branch_flag)
        stl_d = sat_inc(stl_q);
      if (branch_flag)
        brc_d = sat_inc(brc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      cyc_q <= '0;
      stl_q <= '0;
      brc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cyc_q <= cyc_d;
      stl_q <= stl_d;
      brc_q <= brc_d;
    end
  end

  assign pc           = pc_q;
  assign inst_addr    = pc_q[ADDR_SIZE-1:0];
  assign done         = done_w;
  assign cycle_count  = cyc_q;
  assign stall_count  = stl_q;
  assign branch_count = brc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random EX traffic against an edge-level reference model.
module tb_pc_sequencer;

  localparam int AS = 5;
  localparam int ML = 32;
  localparam int DS = 32;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_flag = 1'b0;
  logic [2:0]    ex_branch = '0;
  logic          ex_zero = 1'b0;
  logic [DS-1:0] ex_alu_out = '0;
  logic [AS-1:0] ex_pc = '0;
  logic [AS-1:0] ex_branch_offset = '0;
  logic          ex_branch_direction = 1'b0;

  logic [AS:0]   pc, s_pc;
  logic [AS-1:0] inst_addr, s_inst_addr;
  logic          branch_flag, flush, done, s_branch_flag, s_flush, s_done;
  logic [15:0]   cycle_count, stall_count, branch_count;
  logic [3:0]    s_cycle_count, s_stall_count, s_branch_count;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_SIZE(AS), .MEM_LEN(ML), .DATA_SIZE(DS), .DRAIN_CYCLES(DC), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .stall_flag(stall_flag), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_alu_out(ex_alu_out), .ex_pc(ex_pc), .ex_branch_offset(ex_branch_offset),
    .ex_branch_direction(ex_branch_direction), .pc(pc), .inst_addr(inst_addr),
    .branch_flag(branch_flag), .flush(flush), .done(done), .cycle_count(cycle_count),
    .stall_count(stall_count), .branch_count(branch_count)
  );

  pc_sequencer #(.ADDR_SIZE(AS), .MEM_LEN(ML), .DATA_SIZE(DS), .DRAIN_CYCLES(DC), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .stall_flag(stall_flag), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_alu_out(ex_alu_out), .ex_pc(ex_pc), .ex_branch_offset(ex_branch_offset),
    .ex_branch_direction(ex_branch_direction), .pc(s_pc), .inst_addr(s_inst_addr),
    .branch_flag(s_branch_flag), .flush(s_flush), .done(s_done), .cycle_count(s_cycle_count),
    .stall_count(s_stall_count), .branch_count(s_branch_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pc, sticky done, and how many edges pc has sat at MEM_LEN (-1 when not draining).
  int m_pc, m_drain, m_cyc, m_stl, m_br;
  bit m_done;

  task automatic chk(input string tag, input logic [63:0] obs, input int exp);
    logic [63:0] e;
    e = 64'(exp);
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic bit taken(input int br, input bit z, input logic [31:0] alu);
    case (br)
      1:       return z;
      2:       return !z;
      3:       return alu[31];
      4:       return !alu[31];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int tgt(input int epc, input int off, input bit dir);
    int t;
    t = dir ? epc - off : epc + off;
    if (t < 0 || t >= ML) t = ML;
    return t;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_drain = -1; m_cyc = 0; m_stl = 0; m_br = 0; m_done = 1'b0;
  endtask

  task automatic check_state(input string where);
    chk({where, ".pc"}, 64'(pc), m_pc);
    chk({where, ".inst_addr"}, 64'(inst_addr), m_pc % ML);
    chk({where, ".done"}, 64'(done), int'(m_done));
    chk({where, ".cycle_count"}, 64'(cycle_count), sat(m_cyc, 16));
    chk({where, ".stall_count"}, 64'(stall_count), sat(m_stl, 16));
    chk({where, ".branch_count"}, 64'(branch_count), sat(m_br, 16));
    chk({where, ".s_pc"}, 64'(s_pc), m_pc);
    chk({where, ".s_inst_addr"}, 64'(s_inst_addr), m_pc % ML);
    chk({where, ".s_done"}, 64'(s_done), int'(m_done));
    chk({where, ".s_cycle_count"}, 64'(s_cycle_count), sat(m_cyc, 4));
    chk({where, ".s_stall_count"}, 64'(s_stall_count), sat(m_stl, 4));
    chk({where, ".s_branch_count"}, 64'(s_branch_count), sat(m_br, 4));
  endtask

  // One clock: drive at posedge+1, check combinational outputs, advance, check registered state.
  task automatic step(input bit stall, input int br, input bit zero, input logic [31:0] alu,
                      input int epc, input int off, input bit dir);
    bit bf;
    int npc;
    stall_flag = stall;
    ex_branch = br[2:0];
    ex_zero = zero;
    ex_alu_out = alu;
    ex_pc = epc[AS-1:0];
    ex_branch_offset = off[AS-1:0];
    ex_branch_direction = dir;
    #1;
    bf = taken(br, zero, alu) && !m_done;
    chk("branch_flag", 64'(branch_flag), int'(bf));
    chk("flush", 64'(flush), int'(bf));
    chk("s_branch_flag", 64'(s_branch_flag), int'(bf));
    chk("s_flush", 64'(s_flush), int'(bf));
    @(posedge clk);
    if (!m_done) begin
      m_cyc++;
      if (stall && !bf) m_stl++;
      if (bf) m_br++;
      if (bf) npc = tgt(epc, off, dir);
      else if (stall) npc = m_pc;
      else if (m_pc < ML) npc = m_pc + 1;
      else npc = m_pc;
      if (m_drain >= 0) begin
        if (bf) m_drain = -1;
        else begin
          m_drain++;
          if (m_drain == DC + 1) m_done = 1'b1;
        end
      end else if (npc == ML) begin
        m_drain = 0;
      end
      m_pc = npc;
    end
    #1;
    check_state("step");
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 32'h0, 0, 0, 1'b0);
  endtask

  // Reset asserted between edges: state must clear before any clock edge.
  task automatic apply_reset();
    stall_flag = 1'b0;
    ex_branch = '0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    chk("async_rst.branch_flag", 64'(branch_flag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_state("reset");
    chk("reset.branch_flag", 64'(branch_flag), 0);
    chk("reset.flush", 64'(flush), 0);

    // Straight line: pc 0..32, done four edges later, cycle_count frozen at 36.
    repeat (40) idle();
    chk("straight.pc", 64'(pc), 32);
    chk("straight.done", 64'(done), 1);
    chk("straight.cycle_count", 64'(cycle_count), 36);

    // BEQ backward and BLT/BGE sign-bit cases.
    apply_reset();
    repeat (9) idle();
    step(1'b0, 1, 1'b1, 32'h0, 10, 4, 1'b1);
    chk("beq.pc", 64'(pc), 6);
    chk("beq.branch_count", 64'(branch_count), 1);
    step(1'b0, 3, 1'b0, 32'h8000_0000, 3, 7, 1'b0);
    chk("blt_neg.pc", 64'(pc), 10);
    step(1'b0, 4, 1'b0, 32'h8000_0000, 3, 7, 1'b0);
    chk("bge_neg.pc", 64'(pc), 11);
    step(1'b0, 3, 1'b0, 32'h0, 3, 7, 1'b0);
    chk("blt_zero.pc", 64'(pc), 12);
    step(1'b0, 4, 1'b0, 32'h0, 20, 2, 1'b1);
    chk("bge_zero.pc", 64'(pc), 18);

    // Branch wins over a simultaneous stall; then a plain stall holds.
    step(1'b1, 2, 1'b0, 32'h0, 5, 1, 1'b0);
    chk("br_stall.pc", 64'(pc), 6);
    chk("br_stall.stall_count", 64'(stall_count), 0);
    chk("br_stall.branch_count", 64'(branch_count), 4);
    step(1'b1, 0, 1'b0, 32'h0, 0, 0, 1'b0);
    chk("stall.pc", 64'(pc), 6);

    // Negative target clamps to MEM_LEN, then drains to done.
    step(1'b0, 1, 1'b1, 32'h0, 2, 5, 1'b1);
    chk("oor.pc", 64'(pc), 32);
    repeat (6) idle();
    chk("oor.done", 64'(done), 1);

    // Branch during drain returns to RUN.
    apply_reset();
    repeat (32) idle();
    step(1'b0, 1, 1'b1, 32'h0, 5, 3, 1'b0);
    chk("drain_br.pc", 64'(pc), 8);
    repeat (6) idle();
    chk("drain_br.done", 64'(done), 0);

    // Mid-run reset at pc=17, then stall saturation on the 4-bit instance.
    apply_reset();
    repeat (17) idle();
    chk("mid.pc", 64'(pc), 17);
    apply_reset();
    repeat (20) step(1'b1, 0, 1'b0, 32'h0, 0, 0, 1'b0);
    chk("sat.s_stall_count", 64'(s_stall_count), 15);
    chk("sat.stall_count", 64'(stall_count), 20);

    // Random EX traffic.
    repeat (8) begin
      apply_reset();
      repeat (50) begin
        step(($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
             1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 31)), int'($urandom_range(0, 12)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
